// File: rtl/pixel_filter_pkg.sv
// Shared encodings for the frame pixel filter: operating modes and FSM states.
package pixel_filter_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_GREY   = 2'b01,
        MODE_THRESH = 2'b10,
        MODE_INV    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/pixel_filter_op.sv
// Combinational per-pixel operation: passthrough, greyscale, binary threshold or invert.
// Build option FILTER_LUMA_WEIGHTED_EN switches grey to a 5:9:2 luma weighting (3 channels only).
module pixel_filter_op
    import pixel_filter_pkg::*;
#(
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3
) (
    input  mode_t                  mode_i,
    input  logic [CH_W-1:0]        threshold_i,
    input  logic [NUM_CH*CH_W-1:0] pix_i,
    output logic [NUM_CH*CH_W-1:0] pix_o
);

    logic [CH_W-1:0] grey_s;

`ifdef FILTER_LUMA_WEIGHTED_EN
    localparam int WSUM_W = CH_W + 4;

    logic [WSUM_W-1:0] wsum_s;

    if (NUM_CH != 3) begin : g_bad_num_ch
        $error("pixel_filter_op: luma weighting needs exactly 3 channels");
    end

    // Weights sum to 16, so the shifted result always fits back into one channel.
    assign wsum_s = WSUM_W'(4'd5) * WSUM_W'(pix_i[2*CH_W +: CH_W])
                  + WSUM_W'(4'd9) * WSUM_W'(pix_i[1*CH_W +: CH_W])
                  + WSUM_W'(4'd2) * WSUM_W'(pix_i[0*CH_W +: CH_W]);
    assign grey_s = wsum_s[CH_W+3:4];
`else
    localparam int SUM_W = CH_W + $clog2(NUM_CH);

    logic [SUM_W-1:0] sum_s;

    // Equal-weight channel sum, wide enough that it can never overflow.
    always_comb begin
        sum_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_s = sum_s + SUM_W'(pix_i[c*CH_W +: CH_W]);
        end
    end

    assign grey_s = CH_W'(sum_s / SUM_W'(NUM_CH));
`endif

    // Select the output pixel for the latched mode.
    always_comb begin
        pix_o = pix_i;
        case (mode_i)
            MODE_PASS:   pix_o = pix_i;
            MODE_GREY:   pix_o = {NUM_CH{grey_s}};
            MODE_THRESH: pix_o = (grey_s >= threshold_i) ? {(NUM_CH*CH_W){1'b1}}
                                                         : {(NUM_CH*CH_W){1'b0}};
            MODE_INV:    pix_o = ~pix_i;
            default:     pix_o = pix_i;
        endcase
    end

endmodule

// File: rtl/frame_pixel_filter.sv
// In-place, one-pixel-per-clock point filter over a frame buffer (read, transform, write back).
// Optional build macro FILTER_LUMA_WEIGHTED_EN selects luma-weighted grey in pixel_filter_op.
module frame_pixel_filter
    import pixel_filter_pkg::*;
#(
    parameter int CH_W       = 4,
    parameter int NUM_CH     = 3,
    parameter int ADDR_W     = 17,
    parameter int NUM_PIXELS = 76800,
    parameter int RD_LAT     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_filter,
    input  logic [1:0]             mode_i,
    input  logic [CH_W-1:0]        threshold_i,
    output logic                   led_done,
    output logic                   busy_o,
    output logic [ADDR_W-1:0]      rdaddr_buf2,
    input  logic [NUM_CH*CH_W-1:0] din_buf2,
    output logic [ADDR_W-1:0]      wraddr_buf2,
    output logic [NUM_CH*CH_W-1:0] dout_buf2,
    output logic                   we_buf2
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("frame_pixel_filter: RD_LAT must be at least 1");
    end

    state_t                   state_q;
    mode_t                    mode_q;
    logic [CH_W-1:0]          thr_q;
    logic [ADDR_W-1:0]        rdaddr_q;
    logic                     busy_q;
    logic                     done_q;
    logic [RD_LAT-1:0]        vpipe_q;
    logic [ADDR_W-1:0]        apipe_q [RD_LAT];
    logic                     we_q;
    logic [ADDR_W-1:0]        wraddr_q;
    logic [NUM_CH*CH_W-1:0]   dout_q;
    logic [NUM_CH*CH_W-1:0]   dout_d;
    logic                     rd_valid_s;

    assign rd_valid_s = (state_q == ST_RUN);

    // Control FSM: sequences the read addresses and owns the status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_PASS;
            thr_q    <= '0;
            rdaddr_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_filter) begin
                        state_q  <= ST_RUN;
                        mode_q   <= mode_t'(mode_i);
                        thr_q    <= threshold_i;
                        rdaddr_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (rdaddr_q == LAST_ADDR) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        rdaddr_q <= rdaddr_q + ADDR_W'(1);
                    end
                end
                // The last read is still travelling through the valid pipe on entry here.
                ST_DRAIN: begin
                    if (vpipe_q == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!enable_filter) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    pixel_filter_op #(
        .CH_W   (CH_W),
        .NUM_CH (NUM_CH)
    ) u_op (
        .mode_i      (mode_q),
        .threshold_i (thr_q),
        .pix_i       (din_buf2),
        .pix_o       (dout_d)
    );

    // Valid/address pipe aligned with the read latency, then the registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vpipe_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                apipe_q[i] <= '0;
            end
            we_q     <= 1'b0;
            wraddr_q <= '0;
            dout_q   <= '0;
        end else begin
            vpipe_q[0] <= rd_valid_s;
            apipe_q[0] <= rdaddr_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                apipe_q[i] <= apipe_q[i-1];
            end
            we_q <= vpipe_q[RD_LAT-1];
            if (vpipe_q[RD_LAT-1]) begin
                wraddr_q <= apipe_q[RD_LAT-1];
                dout_q   <= dout_d;
            end
        end
    end

    assign led_done    = done_q;
    assign busy_o      = busy_q;
    assign rdaddr_buf2 = rdaddr_q;
    assign wraddr_buf2 = wraddr_q;
    assign dout_buf2   = dout_q;
    assign we_buf2     = we_q;

endmodule
